// File: rtl/cs_mult_arbiter_if.sv
// Requester/consumer bundle for the shared 4x4 multiplier.
// Master drives requests and operands; slave is the arbiter.
interface cs_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   gnt;
  logic [4*N_REQ-1:0] factor1_in;
  logic [4*N_REQ-1:0] factor2_in;
  logic [8:0]         product_out;
  logic [ID_W-1:0]    product_id;
  logic               product_valid;
  logic               product_ready;

  modport master (
    output req, factor1_in, factor2_in, product_ready,
    input  gnt, product_out, product_id, product_valid
  );

  modport slave (
    input  req, factor1_in, factor2_in, product_ready,
    output gnt, product_out, product_id, product_valid
  );
endinterface

// File: rtl/cs_mult_arbiter.sv
// Round-robin sequencer sharing one carry-save 4x4 multiplier.
// Grant -> operand regs -> product reg -> valid/ready output.
module multiCS4_v1 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] pp [4];
  logic [7:0] s0, c0, s1, c1;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4'b0, a & {4{b[i]}}} << i;
  end

  // Two carry-save rows reduce four partial products; one final add.
  always_comb begin
    s0 = pp[0] ^ pp[1] ^ pp[2];
    c0 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s1 = s0 ^ c0 ^ pp[3];
    c1 = ((s0 & c0) | (s0 & pp[3]) | (c0 & pp[3])) << 1;
    p  = s1 + c1;
  end
endmodule

module cs_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic            clk,
  input logic            rst,
  cs_mult_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, nxt;
  logic [3:0]      opa, opb;
  logic [7:0]      mp;
  logic [8:0]      prod;
  logic [ID_W-1:0] cur_id, pid, last, win;
  logic [ID_W+1:0] base;
  logic            found, take;

  multiCS4_v1 u_mult (
    .a(opa),
    .b(opb),
    .p(mp)
  );

  // Search last+1, last+2, ... so the previous winner ranks last.
  always_comb begin
    logic [ID_W:0] sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sum = {1'b0, last} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ))
        sum = sum - (ID_W+1)'(N_REQ);
      if (!found && bus.req[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  // Next state; take marks the operand capture cycle.
  always_comb begin
    nxt  = state;
    take = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          take = 1'b1;
          nxt  = CALC;
        end
      end
      CALC: nxt = DONE;
      DONE: begin
        if (bus.product_ready) begin
          if (found) begin
            take = 1'b1;
            nxt  = CALC;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
    if (rst) take = 1'b0;
  end

  assign base = {win, 2'b00};

  // State, operand capture and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      cur_id <= '0;
      last   <= ID_W'(N_REQ-1);
      prod   <= '0;
      pid    <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        opa    <= bus.factor1_in[base +: 4];
        opb    <= bus.factor2_in[base +: 4];
        cur_id <= win;
        last   <= win;
      end
      if (state == CALC) begin
        prod <= {1'b0, mp};
        pid  <= cur_id;
      end
    end
  end

  assign bus.gnt           = take ? (N_REQ'(1) << win) : '0;
  assign bus.product_out   = prod;
  assign bus.product_id    = pid;
  assign bus.product_valid = (state == DONE);
endmodule

// File: tb/tb_cs_mult_arbiter.sv
// Bench for cs_mult_arbiter: cycle model with an expected-product
// queue, a vector table and directed multi-cycle sequences.
module tb_cs_mult_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cs_mult_arbiter_if #(.N_REQ(N), .ID_W(W)) bus ();

  cs_mult_arbiter #(.N_REQ(N), .ID_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef enum {M_IDLE, M_CALC, M_DONE} mst_t;
  typedef struct { int id; int prod; } exp_t;
  typedef struct {
    int id; int a; int b; int prod; int gnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   fa [N];
  int   fb [N];
  logic [N-1:0] req_v;
  logic ready;
  logic auto_drop;
  mst_t ms;
  int   m_last;
  exp_t q [$];
  logic [N-1:0] g_seen;
  int   first_gnt;
  int   n_gnt, n_valid, n_acc;
  int   got_prod, got_id;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic drive();
    bus.req = req_v;
    for (int k = 0; k < N; k++) begin
      bus.factor1_in[4*k +: 4] = 4'(fa[k]);
      bus.factor2_in[4*k +: 4] = 4'(fb[k]);
    end
    bus.product_ready = ready;
  endtask

  task automatic step();
    int w;
    logic take;
    logic [N-1:0] eg;
    drive();
    @(negedge clk);
    take = !rst && (req_v != 0) &&
           (ms == M_IDLE || (ms == M_DONE && ready));
    w = -1;
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (m_last + i) % N;
      if (w < 0 && req_v[j]) w = j;
    end
    eg = '0;
    if (take) eg[w] = 1'b1;
    chk("gnt", int'(bus.gnt), int'(eg));
    chk("valid", int'(bus.product_valid), int'(ms == M_DONE));
    if (ms == M_DONE) begin
      if (q.size() == 0) fail_now("scoreboard_empty");
      else begin
        chk("prod", int'(bus.product_out), q[0].prod);
        chk("id", int'(bus.product_id), q[0].id);
      end
    end
    g_seen = bus.gnt;
    if (bus.gnt != 0 && n_gnt == 0) first_gnt = int'(bus.gnt);
    if (bus.gnt != 0) n_gnt++;
    if (bus.product_valid) n_valid++;
    if (rst) begin
      ms = M_IDLE;
      m_last = N - 1;
      q.delete();
    end else begin
      if (ms == M_DONE && ready) begin
        got_prod = int'(bus.product_out);
        got_id   = int'(bus.product_id);
        n_acc++;
        if (q.size() > 0) void'(q.pop_front());
        ms = M_IDLE;
      end else if (ms == M_CALC) begin
        ms = M_DONE;
      end
      if (take) begin
        q.push_back('{w, fa[w] * fb[w]});
        m_last = w;
        ms = M_CALC;
      end
    end
    @(posedge clk);
    #1;
    if (auto_drop) req_v = req_v & ~g_seen;
  endtask

  task automatic serve(int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(req_v == 0 && ms == M_IDLE && q.size() == 0)
               && k < budget);
    if (!(req_v == 0 && ms == M_IDLE && q.size() == 0))
      fail_now("serve_timeout");
  endtask

  task automatic wait_gnt(int budget, string nm);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (g_seen == 0 && k < budget);
    if (g_seen == 0) fail_now(nm);
  endtask

  task automatic clear_counts();
    n_gnt = 0;
    n_valid = 0;
    n_acc = 0;
    first_gnt = 0;
  endtask

  initial begin
    vec_t tv [5];
    int   gid [$];
    int   gcy [$];
    int   exp_seq [5];

    tv[0] = '{2, 15, 15, 225, 4};
    tv[1] = '{0, 0, 9, 0, 1};
    tv[2] = '{3, 15, 1, 15, 8};
    tv[3] = '{1, 8, 8, 64, 2};
    tv[4] = '{2, 1, 13, 13, 4};
    exp_seq = '{0, 1, 2, 3, 0};

    req_v = '0;
    ready = 1'b0;
    auto_drop = 1'b1;
    for (int k = 0; k < N; k++) begin
      fa[k] = 0;
      fb[k] = 0;
    end
    ms = M_IDLE;
    m_last = N - 1;
    clear_counts();
    got_prod = 0;
    got_id = 0;
    g_seen = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_prod", int'(bus.product_out), 0);
      chk("idle_valid", int'(bus.product_valid), 0);
    end

    ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      fa[tv[v].id] = tv[v].a;
      fb[tv[v].id] = tv[v].b;
      req_v = '0;
      req_v[tv[v].id] = 1'b1;
      clear_counts();
      serve(20);
      chk("tv_gnt", first_gnt, tv[v].gnt);
      chk("tv_ngnt", n_gnt, 1);
      chk("tv_nvalid", n_valid, 1);
      chk("tv_prod", got_prod, tv[v].prod);
      chk("tv_id", got_id, tv[v].id);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      fa[k] = k + 1;
      fb[k] = 3;
    end
    auto_drop = 1'b0;
    ready = 1'b1;
    req_v = 4'hF;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int k = 0; k < N; k++)
        if (g_seen[k]) begin
          gid.push_back(k);
          gcy.push_back(c);
        end
    end
    if (gid.size() < 5) fail_now("rr_count");
    else
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", gid[i], exp_seq[i]);
        if (i > 0) chk("rr_spacing", gcy[i] - gcy[i-1], 2);
      end
    auto_drop = 1'b1;
    req_v = '0;
    serve(20);

    fa[2] = 7;
    fb[2] = 9;
    ready = 1'b0;
    req_v = 4'b0100;
    wait_gnt(10, "bp_gnt_timeout");
    fa[0] = 2; fb[0] = 2;
    fa[1] = 3; fb[1] = 3;
    req_v = 4'b0011;
    step();
    for (int c = 0; c < 6; c++) begin
      step();
      chk("bp_prod", int'(bus.product_out), 63);
      chk("bp_valid", int'(bus.product_valid), 1);
      chk("bp_gnt", int'(g_seen), 0);
    end
    ready = 1'b1;
    step();
    chk("bp_next", int'(g_seen), 1);
    serve(40);

    fa[0] = 5;
    fb[0] = 5;
    ready = 1'b1;
    req_v = 4'b0001;
    wait_gnt(10, "rst_gnt_timeout");
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_counts();
    for (int c = 0; c < 4; c++) step();
    chk("rst_novalid", n_valid, 0);
    for (int k = 0; k < N; k++) begin
      fa[k] = 4 + k;
      fb[k] = 2;
    end
    req_v = 4'hF;
    step();
    chk("rst_prio", int'(g_seen), 1);
    serve(40);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        int k;
        fa[N-1] = a;
        fb[N-1] = b;
        req_v = '0;
        req_v[N-1] = 1'b1;
        k = 0;
        while (req_v != 0 && k < 60) begin
          ready = 1'($urandom_range(0, 1));
          step();
          k++;
        end
        if (req_v != 0) fail_now("sweep_timeout");
      end
    ready = 1'b1;
    serve(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
